// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, default width,
// FSM state encoding and the opcode legality check.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NAND, OP_NOR,
            OP_SRA, OP_SRL, OP_SLL, OP_ROL, OP_ROR: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU command sequencer.
// master = requester/consumer plus the ALU itself; slave = the sequencer.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_chain;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
               alu_out, alu_zero,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data,
               rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_chain, rsp_ready,
               alu_out, alu_zero,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data,
               rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives registered operands into a combinational ALU, waits ALU_LAT cycles,
// captures the result and returns it over a valid/ready response channel.
//
// state | meaning
// IDLE  | ready for a request; ALU inputs hold the last operation
// WAIT  | ALU inputs stable, counting down the settle time
// RESP  | captured result presented until the consumer takes it
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             illegal;
    logic [WIDTH-1:0] acc;

    assign bus.req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            illegal       <= 1'b0;
            acc           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.alu_op <= bus.req_op;
                        bus.alu_a  <= bus.req_chain ? acc : bus.req_a;
                        bus.alu_b  <= bus.req_b;
                        illegal    <= !op_legal(bus.req_op);
                        cnt        <= CNT_INIT;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        // An illegal op returns a clean error and leaves the chain value alone.
                        if (illegal) begin
                            bus.rsp_data <= '0;
                            bus.rsp_zero <= 1'b0;
                            bus.rsp_err  <= 1'b1;
                        end else begin
                            bus.rsp_data <= bus.alu_out;
                            bus.rsp_zero <= bus.alu_zero;
                            bus.rsp_err  <= 1'b0;
                            acc          <= bus.alu_out;
                        end
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU
// stub and a transaction-level reference model (result + accumulator).
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int ALU_LAT = 3;
    localparam int W       = 32;

    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] acc_m;

    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

    alu_cmd_sequencer #(.WIDTH(W), .ALU_LAT(ALU_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    alu_fn = a + b;
            4'd1:    alu_fn = a - b;
            4'd2:    alu_fn = a & b;
            4'd3:    alu_fn = a | b;
            4'd4:    alu_fn = ~a;
            4'd5:    alu_fn = ~(a & b);
            4'd6:    alu_fn = ~(a | b);
            4'd8:    alu_fn = $signed(a) >>> sh;
            4'd9:    alu_fn = a >> sh;
            4'd10:   alu_fn = a << sh;
            4'd12:   alu_fn = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
            4'd13:   alu_fn = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            default: alu_fn = 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic is_legal_ref(input logic [3:0] op);
        return !(op == 4'd7 || op == 4'd11 || op >= 4'd14);
    endfunction

    // ALU stub: raises zero on illegal ops so a leaked flag would be visible.
    assign bus.alu_out  = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = is_legal_ref(bus.alu_op) ? (bus.alu_out == '0) : 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic chain, input int hold);
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_d;
        logic         exp_z;
        logic         exp_e;
        int           edges;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_chain = chain;
        chk("req_ready_idle", bus.req_ready, 1'b1);
        exp_a = chain ? acc_m : a;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        chk("alu_a", bus.alu_a, exp_a);
        chk("alu_b", bus.alu_b, b);
        chk("alu_op", bus.alu_op, op);
        edges = 1;
        while (!bus.rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!bus.rsp_valid) bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        bus.rsp_ready = 1'b0;
        chk("rsp_latency", edges, ALU_LAT + 1);
        if (is_legal_ref(op)) begin
            exp_d = alu_fn(op, exp_a, b);
            exp_z = (exp_d == '0);
            exp_e = 1'b0;
            acc_m = exp_d;
        end else begin
            exp_d = '0;
            exp_z = 1'b0;
            exp_e = 1'b1;
        end
        chk("rsp_data", bus.rsp_data, exp_d);
        chk("rsp_zero", bus.rsp_zero, exp_z);
        chk("rsp_err", bus.rsp_err, exp_e);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = OP_ADD;
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            bus.req_chain = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_data", bus.rsp_data, exp_d);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            chk("hold_alu_a", bus.alu_a, exp_a);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("retire_valid", bus.rsp_valid, 1'b0);
        chk("retire_req_ready", bus.req_ready, 1'b1);
        chk("alu_a_persist", bus.alu_a, exp_a);
    endtask

    initial begin
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic seen;
        logic [3:0] legal_ops [12];
        logic [3:0] bad_ops [4];
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13};
        bad_ops   = '{4'd7, 4'd11, 4'd14, 4'd15};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_chain = 1'b0;
        bus.rsp_ready = 1'b0;
        acc_m         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 32'd2, 32'd1, 1'b0, 0);
        run_op(OP_SUB, 32'd5, 32'd5, 1'b0, 0);
        run_op(OP_OR, 32'd2, 32'd1, 1'b0, 0);
        run_op(OP_ADD, 32'd2, 32'd1, 1'b0, 0);
        run_op(OP_ADD, 32'd99, 32'd4, 1'b1, 5);
        run_op(4'b0111, 32'd1, 32'd1, 1'b0, 0);
        run_op(OP_ADD, 32'd50, 32'd1, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) op = bad_ops[$urandom_range(0, 3)];
            else op = legal_ops[$urandom_range(0, 11)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset during WAIT drops the operation and clears the chain value.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_ADD;
        bus.req_a     = 32'd11;
        bus.req_b     = 32'd22;
        bus.req_chain = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_alu_a", bus.alu_a, 0);
        chk("arst_alu_b", bus.alu_b, 0);
        chk("arst_alu_op", bus.alu_op, 0);
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = '0;
        seen  = 1'b0;
        repeat (ALU_LAT + 3) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_rst", seen, 1'b0);
        run_op(OP_ADD, 32'd77, 32'd5, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
